// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared opcodes, sequencer states and helpers for the 9-bit processor
package proc_pkg;

  localparam int DATA_W = 9;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_DECODE = 2'd2,
    S_EXEC   = 2'd3
  } seq_state_t;

  // Legal means the sequencer knows what to do with it: the four proc ops plus halt.
  function automatic logic is_legal_op(input logic [2:0] op);
    return (op == OP_MV) || (op == OP_MVI) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/proc_sequencer.sv
// rtl/proc_sequencer.sv - fetch/decode/run sequencer feeding the 9-bit processor
module proc_sequencer
  import proc_pkg::*;
#(
  parameter int               ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter int               WDOG       = 4
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  input  logic              Stop,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              proc_run,
  output logic [DATA_W-1:0] proc_din,
  input  logic              proc_done,
  output logic              busy,
  output logic              halted,
  output logic              err,
  output logic [ADDR_W-1:0] pc
);

  localparam int CNT_W = (WDOG > 1) ? $clog2(WDOG) : 1;
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG - 1);

  seq_state_t        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [2:0]        r_op;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_stop_q;
  logic              r_halted;
  logic              r_err;

  logic [2:0]        w_op;
  logic              w_dec_halt;
  logic              w_dec_illegal;
  logic              w_dec_mvi;
  logic [ADDR_W-1:0] w_pc_plus1;
  logic [ADDR_W-1:0] w_pc_plus2;

  assign w_op          = mem_rdata[8:6];
  assign w_dec_halt    = (r_state == S_DECODE) && (w_op == OP_HALT);
  assign w_dec_illegal = (r_state == S_DECODE) && !is_legal_op(w_op);
  assign w_dec_mvi     = (r_state == S_DECODE) && (w_op == OP_MVI);
  assign w_pc_plus1    = r_pc + ADDR_W'(1);
  assign w_pc_plus2    = r_pc + ADDR_W'(2);

  // Memory, processor and status outputs decoded from the registered state.
  always_comb begin
    mem_rd   = (r_state == S_FETCH) || w_dec_mvi;
    mem_addr = '0;
    if (r_state == S_FETCH) mem_addr = r_pc;
    else if (w_dec_mvi)     mem_addr = w_pc_plus1;
    proc_run = (r_state == S_DECODE) && !w_dec_halt && !w_dec_illegal;
    proc_din = '0;
    if (proc_run)                                proc_din = mem_rdata;
    else if ((r_state == S_EXEC) && (r_op == OP_MVI)) proc_din = mem_rdata;
    busy   = (r_state != S_IDLE);
    halted = r_halted;
    err    = r_err;
    pc     = r_pc;
  end

  // Sequencer FSM with pc, stop latch and watchdog counter.
  always_ff @(posedge Clock or posedge Resetn) begin
    if (Resetn) begin
      r_state  <= S_IDLE;
      r_pc     <= START_ADDR;
      r_op     <= OP_MV;
      r_cnt    <= '0;
      r_stop_q <= 1'b0;
      r_halted <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start && !Stop) begin
            r_pc     <= START_ADDR;
            r_halted <= 1'b0;
            r_err    <= 1'b0;
            r_state  <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (Stop) r_stop_q <= 1'b1;
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          if (w_dec_halt) begin
            r_halted <= 1'b1;
            r_stop_q <= 1'b0;
            r_state  <= S_IDLE;
          end else if (w_dec_illegal) begin
            r_err    <= 1'b1;
            r_halted <= 1'b1;
            r_stop_q <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            if (Stop) r_stop_q <= 1'b1;
            r_op    <= w_op;
            r_cnt   <= '0;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (proc_done) begin
            r_pc <= (r_op == OP_MVI) ? w_pc_plus2 : w_pc_plus1;
            if (r_stop_q || Stop) begin
              r_halted <= 1'b1;
              r_stop_q <= 1'b0;
              r_state  <= S_IDLE;
            end else begin
              r_state <= S_FETCH;
            end
          end else if (r_cnt == WDOG_LAST) begin
            r_err    <= 1'b1;
            r_halted <= 1'b1;
            r_stop_q <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            if (Stop) r_stop_q <= 1'b1;
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_sequencer.sv
// tb/tb_proc_sequencer.sv - directed bench with processor and memory models
module tb_proc_sequencer;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b1;
  logic       Start = 1'b0;
  logic       Stop = 1'b0;
  logic       mem_rd;
  logic [7:0] mem_addr;
  logic [8:0] mem_rdata = '0;
  logic       proc_run;
  logic [8:0] proc_din;
  logic       proc_done;
  logic       busy;
  logic       halted;
  logic       err;
  logic [7:0] pc;

  int checks = 0;
  int failures = 0;

  proc_sequencer #(.ADDR_W(8), .START_ADDR(8'd0), .WDOG(4)) dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .Stop(Stop),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .proc_run(proc_run), .proc_din(proc_din), .proc_done(proc_done),
    .busy(busy), .halted(halted), .err(err), .pc(pc)
  );

  always #5 Clock = ~Clock;

  // Program memory: one-cycle read latency, data held between reads.
  logic [8:0] mem [0:255];
  always @(posedge Clock) if (mem_rd) mem_rdata <= mem[mem_addr];

  // Processor model: T0 loads IR on Run, mv/mvi finish in T1, add/sub in T3.
  logic [8:0] p_reg [0:7];
  logic [8:0] p_ir, p_a, p_g;
  logic [1:0] p_t;
  logic       done_mask = 1'b0;
  assign proc_done = !done_mask &&
                     (((p_t == 2'd1) && (p_ir[8:7] == 2'b00)) || (p_t == 2'd3));
  always @(posedge Clock or posedge Resetn) begin
    if (Resetn) begin
      p_t <= 2'd0; p_ir <= '0; p_a <= '0; p_g <= '0;
      for (int i = 0; i < 8; i++) p_reg[i] <= '0;
    end else begin
      case (p_t)
        2'd0: if (proc_run) begin p_ir <= proc_din; p_t <= 2'd1; end
        2'd1: begin
          if (p_ir[8:6] == 3'b000) begin p_reg[p_ir[5:3]] <= p_reg[p_ir[2:0]]; p_t <= 2'd0; end
          else if (p_ir[8:6] == 3'b001) begin p_reg[p_ir[5:3]] <= proc_din; p_t <= 2'd0; end
          else begin p_a <= p_reg[p_ir[5:3]]; p_t <= 2'd2; end
        end
        2'd2: begin
          p_g <= (p_ir[8:6] == 3'b010) ? p_a + p_reg[p_ir[2:0]] : p_a - p_reg[p_ir[2:0]];
          p_t <= 2'd3;
        end
        default: begin p_reg[p_ir[5:3]] <= p_g; p_t <= 2'd0; end
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  int n_busy, run_cnt, rd_cnt;
  int run_at [0:7];
  int done_at [0:7];
  logic [8:0] din_run [0:7];
  logic [8:0] r0_at_run [0:7];
  logic [8:0] exec_din;

  // Pulse Start, then sample every cycle #1 after the edge until busy drops.
  task automatic start_and_run(input int stop_n);
    int n;
    Start = 1'b1; @(posedge Clock); #1; Start = 1'b0;
    n = 0; run_cnt = 0; rd_cnt = 0; exec_din = '0;
    for (int i = 0; i < 8; i++) begin run_at[i] = -1; done_at[i] = -1; end
    while (busy && n < 100) begin
      n++;
      if (proc_run && run_cnt < 8) begin
        run_at[run_cnt] = n; din_run[run_cnt] = proc_din; r0_at_run[run_cnt] = p_reg[0];
        run_cnt++;
      end else if (run_cnt > 0 && run_at[0] + 1 == n) begin
        exec_din = proc_din;
      end
      if (proc_done && run_cnt > 0) done_at[run_cnt-1] = n;
      if (mem_rd) rd_cnt++;
      Stop = (n == stop_n);
      @(posedge Clock); #1;
    end
    Stop = 1'b0;
    n_busy = n;
    check("run_timeout", 32'(n < 100), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "time limit");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 9'h1C0;
    repeat (2) @(posedge Clock);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_outs", {27'd0, mem_rd, proc_run, halted, err, 1'b0}, 32'd0);
    check("rst_din", 32'(proc_din), 32'd0);
    Resetn = 1'b0;
    @(posedge Clock); #1;

    // Start together with Stop is ignored.
    Start = 1'b1; Stop = 1'b1; @(posedge Clock); #1; Start = 1'b0; Stop = 1'b0;
    check("start_stop_idle", 32'(busy), 32'd0);

    // 1: mv R1,R2 then halt
    mem[0] = 9'h00A; mem[1] = 9'h1C0;
    start_and_run(0);
    check("t1_runs", run_cnt, 1);
    check("t1_din", 32'(din_run[0]), 32'h00A);
    check("t1_done_lat", done_at[0] - run_at[0], 1);
    check("t1_halted", 32'(halted), 32'd1);
    check("t1_pc", 32'(pc), 32'd1);
    check("t1_busy_err", {30'd0, busy, err}, 32'd0);
    check("t1_cycles", n_busy, 5);

    // 2: mvi R3,0x055 then halt
    mem[0] = 9'h058; mem[1] = 9'h055; mem[2] = 9'h1C0;
    start_and_run(0);
    check("t2_exec_din", 32'(exec_din), 32'h055);
    check("t2_r3", 32'(p_reg[3]), 32'h055);
    check("t2_pc", 32'(pc), 32'd2);
    check("t2_halted", 32'(halted), 32'd1);

    // 3: mvi R0,5; mvi R1,3; add; sub; halt
    mem[0] = 9'h040; mem[1] = 9'h005; mem[2] = 9'h048; mem[3] = 9'h003;
    mem[4] = 9'h081; mem[5] = 9'h0C1; mem[6] = 9'h1C0;
    start_and_run(0);
    check("t3_cycles", n_busy, 18);
    check("t3_add_exec", done_at[2] - run_at[2], 3);
    check("t3_r0_after_add", 32'(r0_at_run[3]), 32'd8);
    check("t3_r0_final", 32'(p_reg[0]), 32'd5);
    check("t3_pc", 32'(pc), 32'd6);

    // 4: illegal opcode, then Start clears the sticky flags
    mem[0] = 9'h100;
    start_and_run(0);
    check("t4_runs", run_cnt, 0);
    check("t4_cycles", n_busy, 2);
    check("t4_err_halt", {30'd0, err, halted}, 32'd3);
    check("t4_pc", 32'(pc), 32'd0);
    mem[0] = 9'h1C0;
    Start = 1'b1; @(posedge Clock); #1; Start = 1'b0;
    check("t4_clear", {30'd0, err, halted}, 32'd0);
    for (int i = 0; i < 10 && busy; i++) begin @(posedge Clock); #1; end
    check("t4_clear_done", 32'(busy), 32'd0);

    // 5: Stop during add EXEC
    mem[0] = 9'h040; mem[1] = 9'h005; mem[2] = 9'h048; mem[3] = 9'h003;
    mem[4] = 9'h081; mem[5] = 9'h010; mem[6] = 9'h1C0;
    start_and_run(9);
    check("t5_r0", 32'(p_reg[0]), 32'd8);
    check("t5_pc", 32'(pc), 32'd5);
    check("t5_halted", {30'd0, halted, err}, 32'd2);
    check("t5_reads", rd_cnt, 5);
    check("t5_cycles", n_busy, 11);

    // 6a: watchdog on mv with Done suppressed
    mem[0] = 9'h00A; mem[1] = 9'h1C0;
    done_mask = 1'b1;
    start_and_run(0);
    done_mask = 1'b0;
    check("t6_cycles", n_busy, 6);
    check("t6_err_halt", {30'd0, err, halted}, 32'd3);
    check("t6_pc", 32'(pc), 32'd0);

    // 6b: reset in the middle of the second instruction's EXEC
    mem[0] = 9'h00A; mem[1] = 9'h019; mem[2] = 9'h1C0;
    Start = 1'b1; @(posedge Clock); #1; Start = 1'b0;
    for (int n = 1; n < 6; n++) begin
      if (n == 5) done_mask = 1'b1;
      @(posedge Clock); #1;
    end
    check("t6_pre_pc", 32'(pc), 32'd1);
    check("t6_pre_busy", 32'(busy), 32'd1);
    Resetn = 1'b1; #1;
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_pc", 32'(pc), 32'd0);
    check("t6_rst_outs", {27'd0, mem_rd, proc_run, halted, err, 1'b0}, 32'd0);
    check("t6_rst_bus", {15'd0, proc_din, mem_addr}, 32'd0);
    done_mask = 1'b0;
    @(posedge Clock); #3;
    Resetn = 1'b0;
    @(posedge Clock); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
